clmul16_karatsuba_seq: RTL and testbench

- Sequential 16x16 carry-less (GF(2) polynomial) multiplier built on a single shared 8x8 carry-less multiplier core.
- The core is time-multiplexed over three Karatsuba partial products: z0 = lo*lo, z2 = hi*hi, m = (lo^hi)*(lo^hi).
- The partials are then combined with the XOR overlap-sum stage into a 31-bit product.
- Sits between the operand-issue logic and the downstream reduction/accumulate logic; all ports use a valid/ready handshake.

---
 rtl/clmul16_karatsuba_seq.sv | 190 +++++++++++++++++++
 tb/tb_clmul16_karatsuba_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clmul16_karatsuba_seq.sv
// Sequential carry-less (GF(2) polynomial) multiplier.
// A single HxH carry-less core is reused for the three Karatsuba partial
// products z0 = lo*lo, z2 = hi*hi and m = (lo^hi)*(lo^hi). The overlap-sum
// combine p = z0 ^ (o << H) ^ (z2 << 2H), with o = m ^ z0 ^ z2, is applied
// in the cycle that produces m.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | in_ready high; captures a/b on in_valid
// MUL_LO  | core computes a_lo*b_lo into z0
// MUL_HI  | core computes a_hi*b_hi into z2
// MUL_MID | core computes (a_lo^a_hi)*(b_lo^b_hi); combined product into p
// DONE    | out_valid high, p held until out_ready

module clmul16_karatsuba_seq_core #(
    parameter int H = 8
) (
    input  logic [H-1:0]   x_i,
    input  logic [H-1:0]   y_i,
    output logic [2*H-2:0] z_o
);

    logic [2*H-2:0] x_ext;

    assign x_ext = {{(H-1){1'b0}}, x_i};

    // Shift-and-XOR partial product accumulation, no carries
    always_comb begin
        z_o = '0;
        for (int i = 0; i < H; i++) begin
            if (y_i[i]) begin
                z_o = z_o ^ (x_ext << i);
            end
        end
    end

endmodule

module clmul16_karatsuba_seq #(
    parameter  int W  = 16,
    localparam int PW = 2*W-1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p,
    output logic          busy
);

    localparam int H  = W/2;
    localparam int ZW = 2*H-1;

    if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
        $error("clmul16_karatsuba_seq: W must be even and at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_LO,
        S_MUL_HI,
        S_MUL_MID,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [ZW-1:0]  z0_q, z0_d;
    logic [ZW-1:0]  z2_q, z2_d;
    logic [PW-1:0]  p_q, p_d;

    logic [H-1:0]   core_x;
    logic [H-1:0]   core_y;
    logic [ZW-1:0]  core_z;
    logic [ZW-1:0]  mid_o;
    logic [PW-1:0]  comb_p;

    // Operand selection for the shared core, steered by the current phase
    always_comb begin
        core_x = a_q[H-1:0];
        core_y = b_q[H-1:0];
        case (state_q)
            S_MUL_HI: begin
                core_x = a_q[W-1:H];
                core_y = b_q[W-1:H];
            end
            S_MUL_MID: begin
                core_x = a_q[H-1:0] ^ a_q[W-1:H];
                core_y = b_q[H-1:0] ^ b_q[W-1:H];
            end
            default: begin
                core_x = a_q[H-1:0];
                core_y = b_q[H-1:0];
            end
        endcase
    end

    clmul16_karatsuba_seq_core #(
        .H(H)
    ) u_core (
        .x_i(core_x),
        .y_i(core_y),
        .z_o(core_z)
    );

    // Overlap-sum: core_z is m while in MUL_MID, which is the only time comb_p is used
    assign mid_o  = core_z ^ z0_q ^ z2_q;
    assign comb_p = {{(PW-ZW){1'b0}}, z0_q}
                  ^ ({{(PW-ZW){1'b0}}, mid_o} << H)
                  ^ ({{(PW-ZW){1'b0}}, z2_q}  << (2*H));

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        z0_d      = z0_q;
        z2_d      = z2_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_MUL_LO;
                end
            end
            S_MUL_LO: begin
                z0_d    = core_z;
                state_d = S_MUL_HI;
            end
            S_MUL_HI: begin
                z2_d    = core_z;
                state_d = S_MUL_MID;
            end
            S_MUL_MID: begin
                p_d     = comb_p;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, partial-product and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            z0_q <= '0;
            z2_q <= '0;
            p_q  <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            z0_q <= z0_d;
            z2_q <= z2_d;
            p_q  <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_clmul16_karatsuba_seq.sv
module tb_clmul16_karatsuba_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] p;
    logic        busy;

    int checks;
    int errors;

    clmul16_karatsuba_seq #(.W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [30:0] ref_clmul(input logic [15:0] x, input logic [15:0] y);
        logic [30:0] r;
        logic [30:0] xe;
        r  = '0;
        xe = {15'd0, x};
        for (int i = 0; i < 16; i++) begin
            if (y[i]) r = r ^ (xe << i);
        end
        return r;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    // The accept edge is the rising edge right after in_valid is set with in_ready high;
    // out_valid must first be seen on the 4th falling edge after that point.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [30:0] expv, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready);
        end
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = ~av; b = ~bv;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected 4", nm, n);
        end
        checks++;
        if (p !== expv) begin
            errors++;
            $display("FAIL %s_p: got %h expected %h", nm, p, expv);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h0003; b = 16'h0003; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (p !== 31'd0) begin errors++; $display("FAIL reset_p: got %h expected 0", p); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b out_valid=%b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_directed();
        run_op(16'h0003, 16'h0003, 31'h0000_0005, "d_3x3");
        run_op(16'h0100, 16'h0100, 31'h0001_0000, "d_hi_only");
        run_op(16'h8000, 16'h8000, 31'h4000_0000, "d_msb");
        run_op(16'hFFFF, 16'hFFFF, 31'h5555_5555, "d_ones");
        run_op(16'hFFFF, 16'h0001, 31'h0000_FFFF, "d_mid");
        run_op(16'h00FF, 16'h0101, 31'h0000_FFFF, "d_lo_x_split");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1 || p !== 31'h0000_FFFF) begin
            errors++;
            $display("FAIL bp_first: out_valid=%b p=%h expected 1/0000ffff", out_valid, p);
        end
        a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || p !== 31'h0000_FFFF || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b p=%h in_ready=%b expected 1/0000ffff/0",
                         i, out_valid, p, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: busy=%b expected 1", busy); end
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4 || p !== 31'h0000_000F) begin
            errors++;
            $display("FAIL bp_next_p: cycles=%0d p=%h expected 4/0000000f", n, p);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || p !== 31'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_state: busy=%b out_valid=%b p=%h in_ready=%b expected 0/0/0/1",
                     busy, out_valid, p, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rmid_no_out: got %0d valid cycles expected 0", seen); end
        run_op(16'h0003, 16'h0005, 31'h0000_000F, "rmid_after");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a = 16'h0100; b = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 16'h8000; b = 16'h8000;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4 || p !== 31'h0001_0000) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d p=%h expected 4/00010000", n, p);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4 || p !== 31'h4000_0000) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d p=%h expected 4/40000000", n, p);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int n;
        int viol;
        logic [15:0] ra, rb;
        logic [30:0] expv;
        logic xfer, done, pchk;
        viol = 0;
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
            expv = ref_clmul(ra, rb);
            a = ra; b = rb; in_valid = 1'b1;
            n = 0;
            while (in_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_accept: pair %0d in_ready=%b expected 1", k, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
            done = 1'b0; pchk = 1'b0; n = 0;
            while (!done && n < 60) begin
                if (in_ready === 1'b1 && busy === 1'b1) viol++;
                out_ready = 1'($urandom_range(0, 1));
                xfer = 1'b0;
                if (out_valid === 1'b1) begin
                    if (!pchk) begin
                        checks++;
                        if (p !== expv) begin
                            errors++;
                            $display("FAIL rnd_p: a=%h b=%h got %h expected %h", ra, rb, p, expv);
                        end
                        pchk = 1'b1;
                    end
                    xfer = out_ready;
                end
                @(negedge clk);
                n++;
                if (xfer) done = 1'b1;
            end
            out_ready = 1'b0;
            checks++;
            if (!done || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_complete: pair %0d done=%b in_ready=%b expected 1/1", k, done, in_ready);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL rnd_in_ready_busy: got %0d cycles expected 0", viol);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
